// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one single-port frame-buffer BRAM between the VGA pixel reader and the
// capture writer. The reader always wins and is never stalled. Writes wait in
// a small in-order FIFO and are drained only in cycles where the reader is idle.
//
// Ports
//   CLK, RESET             pixel clock, synchronous active-high reset
//   RD_REQ, RD_ADDR        reader request and address
//   RD_DATA, RD_VALID      read data, two cycles after the request
//   WR_VALID, WR_READY     writer handshake into the FIFO
//   WR_ADDR, WR_DATA       write entry
//   BRAM_ADDR/DIN/WE       registered BRAM port controls
//   BRAM_DOUT              BRAM read data, one cycle after BRAM_ADDR
//   FIFO_LEVEL             current FIFO occupancy (0..FIFO_DEPTH)
//   STARVED                sticky: FIFO stayed full under reader traffic too long
//
// Grant states
//   state        | meaning
//   GRANT_IDLE   | no BRAM access this cycle, address held
//   GRANT_READ   | BRAM addressed by the reader
//   GRANT_WRITE  | FIFO head being written into the BRAM
module bram_port_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          RD_REQ,
    input  logic [ADDR_W-1:0]             RD_ADDR,
    output logic [DATA_W-1:0]             RD_DATA,
    output logic                          RD_VALID,
    input  logic                          WR_VALID,
    output logic                          WR_READY,
    input  logic [ADDR_W-1:0]             WR_ADDR,
    input  logic [DATA_W-1:0]             WR_DATA,
    output logic [ADDR_W-1:0]             BRAM_ADDR,
    output logic [DATA_W-1:0]             BRAM_DIN,
    output logic                          BRAM_WE,
    input  logic [DATA_W-1:0]             BRAM_DOUT,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          STARVED
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);
    localparam logic [15:0]      STARVE_MAX = 16'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GRANT_IDLE,
        GRANT_READ,
        GRANT_WRITE
    } grant_t;

    grant_t grant, grant_next;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [15:0]       starve_cnt;
    logic              starved_q;
    logic              push, pop;

    // Ready comes from the registered level only, so an entry accepted this
    // cycle can never be popped before the next one.
    assign WR_READY   = !RESET && (level != LVL_FULL);
    assign push       = WR_VALID && WR_READY;
    assign pop        = (grant_next == GRANT_WRITE);
    assign FIFO_LEVEL = level;
    assign STARVED    = starved_q;
    assign RD_DATA    = BRAM_DOUT;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            grant <= GRANT_IDLE;
        end else begin
            grant <= grant_next;
        end
    end

    always_comb begin
        grant_next = GRANT_IDLE;
        if (RD_REQ) begin
            grant_next = GRANT_READ;
        end else if (level != '0) begin
            grant_next = GRANT_WRITE;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_addr[wr_ptr] <= WR_ADDR;
            fifo_data[wr_ptr] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            BRAM_ADDR <= '0;
            BRAM_DIN  <= '0;
            BRAM_WE   <= 1'b0;
            RD_VALID  <= 1'b0;
        end else begin
            RD_VALID <= (grant == GRANT_READ);
            case (grant_next)
                GRANT_READ: begin
                    BRAM_ADDR <= RD_ADDR;
                    BRAM_WE   <= 1'b0;
                end
                GRANT_WRITE: begin
                    BRAM_ADDR <= fifo_addr[rd_ptr];
                    BRAM_DIN  <= fifo_data[rd_ptr];
                    BRAM_WE   <= 1'b1;
                end
                default: begin
                    BRAM_WE <= 1'b0;
                end
            endcase
        end
    end

    // Counter saturates at the limit; the flag is set on the same edge the
    // counter reaches it and then only RESET clears it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            starve_cnt <= '0;
            starved_q  <= 1'b0;
        end else if (pop) begin
            starve_cnt <= '0;
        end else if ((level == LVL_FULL) && RD_REQ && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 16'd1;
            if (starve_cnt + 16'd1 == STARVE_MAX) begin
                starved_q <= 1'b1;
            end
        end
    end

endmodule
